flag_pulse_gen: RTL

FLAG_PULSE_GEN -- requirements
Module: flag_pulse_gen

---
 rtl/flag_pulse_gen_pkg.sv | 16 +
 rtl/flag_pulse_gen_cnt.sv | 30 +++
 rtl/flag_pulse_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/flag_pulse_gen_pkg.sv
// Shared definitions for the flag-driven pulse generator: state encoding and default width.
package flag_pulse_gen_pkg;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DLY  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DLY  = ST_DLY,
    HIGH = ST_HIGH
  } state_t;

endpackage

// File: rtl/flag_pulse_gen_cnt.sv
// Loadable, CE-gated down counter that saturates at zero and reports when it is empty.
module pulse_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (ce) begin
      if (load) begin
        count <= value;
      end else if (dec && !zero_c) begin
        count <= count - W'(1);
      end
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/flag_pulse_gen.sv
// Flag-triggered pulse train generator: DELAY low / WIDTH high, REPEAT times (0 = forever),
// with abort, sticky overrun and a one-cycle completion flag.
module flag_pulse_gen
  import flag_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [CNT_WIDTH-1:0] DELAY,
  input  logic [CNT_WIDTH-1:0] WIDTH,
  input  logic [CNT_WIDTH-1:0] REPEAT,
  output logic                 PULSE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERRUN
);

  state_t               state;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] d_lat;
  logic [CNT_WIDTH-1:0] w_lat;
  logic                 cont;
  logic                 ph_load;
  logic                 ph_dec;
  logic [CNT_WIDTH-1:0] ph_val;
  logic                 ph_zero;
  logic                 rp_load;
  logic                 rp_dec;
  logic                 rp_zero;
  logic                 lat_en;
  logic                 done_c;
  logic                 ovr_c;

  pulse_cnt #(.W(CNT_WIDTH)) u_phase_cnt (
    .clk    (CLK),
    .reset  (RESET),
    .ce     (CE),
    .load   (ph_load),
    .dec    (ph_dec),
    .value  (ph_val),
    .zero_c (ph_zero)
  );

  // Holds the number of pulses still to follow the current one.
  pulse_cnt #(.W(CNT_WIDTH)) u_repeat_cnt (
    .clk    (CLK),
    .reset  (RESET),
    .ce     (CE),
    .load   (rp_load),
    .dec    (rp_dec),
    .value  (REPEAT - CNT_WIDTH'(1)),
    .zero_c (rp_zero)
  );

  // The accept cycle is itself a low cycle, so every run begins in DLY; a zero DELAY
  // between repeats still leaves one low cycle so consecutive pulses stay distinct.
  always_comb begin
    state_d = state;
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    rp_load = 1'b0;
    rp_dec  = 1'b0;
    lat_en  = 1'b0;
    done_c  = 1'b0;
    ovr_c   = OVERRUN | (START && (state != IDLE));
    case (state)
      IDLE: begin
        if (START && !STOP && (WIDTH != '0)) begin
          state_d = DLY;
          lat_en  = 1'b1;
          ph_load = 1'b1;
          ph_val  = DELAY;
          rp_load = 1'b1;
        end
      end
      DLY: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          state_d = HIGH;
          ph_load = 1'b1;
          ph_val  = w_lat - CNT_WIDTH'(1);
        end else begin
          ph_dec = 1'b1;
        end
      end
      HIGH: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (!ph_zero) begin
          ph_dec = 1'b1;
        end else if (!cont && rp_zero) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end else begin
          state_d = DLY;
          ph_load = 1'b1;
          ph_val  = (d_lat == '0) ? '0 : d_lat - CNT_WIDTH'(1);
          rp_dec  = !cont;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      PULSE   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVERRUN <= 1'b0;
      d_lat   <= '0;
      w_lat   <= '0;
      cont    <= 1'b0;
    end else begin
      DONE <= CE && done_c;
      if (CE) begin
        state   <= state_d;
        PULSE   <= (state_d == HIGH);
        BUSY    <= (state_d != IDLE);
        OVERRUN <= ovr_c;
        if (lat_en) begin
          d_lat <= DELAY;
          w_lat <= WIDTH;
          cont  <= (REPEAT == '0);
        end
      end
    end
  end

endmodule
